// File: rtl/dist_sq_if.sv
// ---------------------------------------------------------------------------
// dist_sq_if
// Handshake and data bundle between a requester and dist_sq_unit.
//   W        coordinate width; dist_sq is 2W+1 bits
//   start    request, sampled by the unit only while idle
//   x1,y1    point 1 coordinates (unsigned)
//   x2,y2    point 2 coordinates (unsigned)
//   busy     computation in flight
//   done     one-cycle pulse, dist_sq valid from this cycle
//   dist_sq  squared distance, held until the next done
//   ovf      clamp flag (only meaningful with DIST_SQ_CLAMP_EN)
// Modports: master = requester side, slave = dist_sq_unit side.
// ---------------------------------------------------------------------------
interface dist_sq_if #(
  parameter int W = 7
);
  logic             start;
  logic [W-1:0]     x1;
  logic [W-1:0]     y1;
  logic [W-1:0]     x2;
  logic [W-1:0]     y2;
  logic             busy;
  logic             done;
  logic [2*W:0]     dist_sq;
  logic             ovf;

  modport master (
    output start, x1, y1, x2, y2,
    input  busy, done, dist_sq, ovf
  );

  modport slave (
    input  start, x1, y1, x2, y2,
    output busy, done, dist_sq, ovf
  );
endinterface

// File: rtl/dist_sq_unit.sv
// ---------------------------------------------------------------------------
// dist_sq_unit
// Sequential squared Euclidean distance (x1-x2)^2 + (y1-y2)^2 between two
// W-bit points, built from a shift-add squarer that retires one multiplier
// bit per clock: W cycles for the X term, then W cycles for the Y term.
// Feeds the radicand of the integer square-root block.
//
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    dist_sq_if.slave (start, x1, y1, x2, y2 in;
//          busy, done, dist_sq, ovf out)
//
// Configuration macro: DIST_SQ_CLAMP_EN
//   defined   : results above 2^(2W)-1 are clamped to 2^(2W)-1 and ovf is set
//   undefined : full 2W+1 bit result, ovf is constant 0
// ---------------------------------------------------------------------------
module dist_sq_unit #(
  parameter int W = 7
) (
  input  logic     clk,
  input  logic     reset,
  dist_sq_if.slave bus
);

  localparam int AW = 2 * W + 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_X = 2'd1,
    SQ_Y = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [W-1:0]    dx_r, dx_nxt_s;
  logic [W-1:0]    dy_r, dy_nxt_s;
  logic [AW-1:0]   acc_r, acc_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            done_r, done_nxt_s;
  logic [AW-1:0]   dist_r, dist_nxt_s;
  logic            ovf_r, ovf_nxt_s;

  logic [W-1:0]    operand_s;
  logic [AW-1:0]   addend_s;
  logic [AW-1:0]   acc_step_s;

  // Larger minus smaller keeps the difference unsigned and order independent.
  function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  // Shift-add step: add operand<<i when bit i of the operand is set.
  always_comb begin
    operand_s = dx_r;
    if (state_r == SQ_Y) begin
      operand_s = dy_r;
    end else begin
      operand_s = dx_r;
    end
    addend_s = AW'(operand_s) << cnt_r;
    if (operand_s[cnt_r]) begin
      acc_step_s = acc_r + addend_s;
    end else begin
      acc_step_s = acc_r;
    end
  end

  // Next-state and next-output logic of the IDLE -> SQ_X -> SQ_Y sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    dx_nxt_s    = dx_r;
    dy_nxt_s    = dy_r;
    acc_nxt_s   = acc_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    dist_nxt_s  = dist_r;
    ovf_nxt_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          dx_nxt_s    = abs_diff(bus.x1, bus.x2);
          dy_nxt_s    = abs_diff(bus.y1, bus.y2);
          acc_nxt_s   = {AW{1'b0}};
          cnt_nxt_s   = {CW{1'b0}};
          busy_nxt_s  = 1'b1;
          state_nxt_s = SQ_X;
        end else begin
          busy_nxt_s  = 1'b0;
        end
      end
      SQ_X: begin
        acc_nxt_s = acc_step_s;
        if (cnt_r == LAST_BIT) begin
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = SQ_Y;
        end else begin
          cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      SQ_Y: begin
        acc_nxt_s = acc_step_s;
        if (cnt_r == LAST_BIT) begin
          // Final step: publish including this cycle's partial product.
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = IDLE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
`ifdef DIST_SQ_CLAMP_EN
          if (acc_step_s > {1'b0, {(2*W){1'b1}}}) begin
            dist_nxt_s = {1'b0, {(2*W){1'b1}}};
            ovf_nxt_s  = 1'b1;
          end else begin
            dist_nxt_s = acc_step_s;
            ovf_nxt_s  = 1'b0;
          end
`else
          dist_nxt_s  = acc_step_s;
          ovf_nxt_s   = 1'b0;
`endif
        end else begin
          cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts and clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      dx_r    <= {W{1'b0}};
      dy_r    <= {W{1'b0}};
      acc_r   <= {AW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dist_r  <= {AW{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dx_r    <= dx_nxt_s;
      dy_r    <= dy_nxt_s;
      acc_r   <= acc_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      dist_r  <= dist_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.dist_sq = dist_r;
  assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_dist_sq_unit.sv
// ---------------------------------------------------------------------------
// tb_dist_sq_unit
// Self-checking bench for dist_sq_unit (W=7). Expected results come from a
// plain-arithmetic model of the squared distance (with optional clamp when
// DIST_SQ_CLAMP_EN is defined). Inputs are driven and outputs sampled 1 time
// unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_dist_sq_unit;

  localparam int W   = 7;
  localparam int LAT = 2 * W;

  logic clk;
  logic reset;
  int   tests_run;
  int   fails;

  dist_sq_if #(.W(W)) bus ();

  dist_sq_unit #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: squared Euclidean distance with integer arithmetic.
  function automatic int ref_dist(input int ax1, input int ay1, input int ax2, input int ay2);
    int d;
    d = (ax1 - ax2) * (ax1 - ax2) + (ay1 - ay2) * (ay1 - ay2);
`ifdef DIST_SQ_CLAMP_EN
    if (d > 16383) d = 16383;
`endif
    return d;
  endfunction

  function automatic int ref_ovf(input int ax1, input int ay1, input int ax2, input int ay2);
`ifdef DIST_SQ_CLAMP_EN
    return ((ax1 - ax2) * (ax1 - ax2) + (ay1 - ay2) * (ay1 - ay2) > 16383) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pts(input int ax1, input int ay1, input int ax2, input int ay2);
    bus.x1 = 7'(ax1);
    bus.y1 = 7'(ay1);
    bus.x2 = 7'(ax2);
    bus.y2 = 7'(ay2);
  endtask

  // One-cycle start, then count edges until done (lat = -1 on timeout).
  task automatic run_op(input int ax1, input int ay1, input int ax2, input int ay2,
                        output int lat, output int res, output int ov);
    set_pts(ax1, ay1, ax2, ay2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = -1;
    res = -1;
    ov  = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus.done === 1'b1) begin
        lat = c;
        res = int'(bus.dist_sq);
        ov  = int'(bus.ovf);
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input int ax1, input int ay1, input int ax2, input int ay2);
    int lat, res, ov, exp_d, exp_o;
    exp_d = ref_dist(ax1, ay1, ax2, ay2);
    exp_o = ref_ovf(ax1, ay1, ax2, ay2);
    run_op(ax1, ay1, ax2, ay2, lat, res, ov);
    tests_run++;
    if (lat !== LAT) begin
      fails++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
    end
    tests_run++;
    if (res !== exp_d) begin
      fails++;
      $display("FAIL %s dist_sq: got %0d expected %0d", name, res, exp_d);
    end
    tests_run++;
    if (ov !== exp_o) begin
      fails++;
      $display("FAIL %s ovf: got %0d expected %0d", name, ov, exp_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    set_pts(1, 2, 3, 4);
    step();
    step();
    bus.start = 1'b0;
    step();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dist_sq !== 15'd0 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b dist_sq=%0d ovf=%b expected all 0",
               bus.busy, bus.done, bus.dist_sq, bus.ovf);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    check_op("basic_3_4", 0, 0, 3, 4);
    // done is a single-cycle pulse and the result is held afterwards.
    step();
    tests_run++;
    if (bus.done !== 1'b0 || bus.dist_sq !== 15'd25) begin
      fails++;
      $display("FAIL done_pulse: got done=%b dist_sq=%0d expected done=0 dist_sq=25", bus.done, bus.dist_sq);
    end
  endtask

  task automatic test_swap_identical();
    check_op("swapped", 3, 4, 0, 0);
    check_op("identical", 50, 50, 50, 50);
  endtask

  task automatic test_extremes();
    check_op("max_dist", 127, 127, 0, 0);
    check_op("after_max", 0, 0, 1, 1);
    check_op("max_x_only", 0, 127, 127, 127);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      check_op("random", int'($urandom_range(127, 0)), int'($urandom_range(127, 0)),
               int'($urandom_range(127, 0)), int'($urandom_range(127, 0)));
    end
  endtask

  task automatic test_start_while_busy();
    int dones, res;
    dones = 0;
    res = -1;
    set_pts(20, 30, 27, 6);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3 || c == 10) begin
        bus.start = 1'b1;
        set_pts(100, 5, 7, 90);
      end else begin
        bus.start = 1'b0;
      end
      step();
      if (bus.done === 1'b1) begin
        dones++;
        if (dones == 1) res = int'(bus.dist_sq);
      end
    end
    bus.start = 1'b0;
    tests_run++;
    if (dones !== 1) begin
      fails++;
      $display("FAIL busy_start_dones: got %0d expected 1", dones);
    end
    tests_run++;
    if (res !== ref_dist(20, 30, 27, 6)) begin
      fails++;
      $display("FAIL busy_start_result: got %0d expected %0d", res, ref_dist(20, 30, 27, 6));
    end
  endtask

  task automatic test_abort_reset();
    int dones;
    dones = 0;
    set_pts(9, 100, 60, 2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.dist_sq !== 15'd0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset: got busy=%b dist_sq=%0d done=%b expected 0 0 0",
               bus.busy, bus.dist_sq, bus.done);
    end
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.done === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
    end
    check_op("after_abort", 10, 20, 13, 16);
  endtask

  task automatic test_back_to_back();
    int last, ndone;
    last = 0;
    ndone = 0;
    set_pts(10, 20, 13, 16);
    bus.start = 1'b1;
    step();
    for (int c = 1; c <= 50; c++) begin
      step();
      if (bus.done === 1'b1) begin
        ndone++;
        tests_run++;
        if ((c - last) !== ((ndone == 1) ? LAT : LAT + 1) || bus.dist_sq !== 15'd25 || bus.busy !== 1'b0) begin
          fails++;
          $display("FAIL b2b_done: got interval=%0d dist_sq=%0d busy=%b expected %0d 25 0",
                   c - last, bus.dist_sq, bus.busy, (ndone == 1) ? LAT : LAT + 1);
        end
        last = c;
      end else if (bus.busy !== 1'b1) begin
        tests_run++;
        fails++;
        $display("FAIL b2b_busy: got busy=%b at cycle %0d expected 1", bus.busy, c);
      end
    end
    tests_run++;
    if (ndone !== 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d done pulses expected 3", ndone);
    end
    bus.start = 1'b0;
    for (int c = 0; c < 20; c++) step();
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    set_pts(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_swap_identical();
    test_extremes();
    test_random();
    test_start_while_busy();
    test_abort_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
